scic_io_port: RTL and testbench



---
 rtl/scic_io_port.sv | 115 +++++++++++
 tb/tb_scic_io_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scic_io_port.sv
// rtl/scic_io_port.sv - SCIC memory-mapped LED/switch I/O responder
module scic_io_port #(
  parameter int                    ADDR_WIDTH      = 8,
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR        = 8'hF0,
  parameter logic [ADDR_WIDTH-1:0] SW_ADDR         = 8'hF1,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR       = 8'hF2,
  parameter int                    DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_ack,
  input  logic [3:0]            switches,
  output logic [3:0]            LEDs
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);

  logic [3:0]            sync1;
  logic [3:0]            sync2;
  logic [3:0]            stable;
  logic                  changed;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_step;
  logic [CW-1:0]         cnt_next;
  logic                  deb_hit;
  logic                  led_wr;
  logic                  stat_rd;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_wdata;

  // Only the low nibble of write data is ever stored.
  assign unused_wdata = ^(bus_wdata >> 4);

  // Debounce decision on the value sync2 is about to take (sync1), so the
  // stable register follows sync2 on the very edge the count completes.
  always_comb begin
    cnt_step = '0;
    cnt_next = '0;
    deb_hit  = 1'b0;
    if (sync1 != stable) begin
      cnt_step = (sync1 != sync2) ? CW'(1) : cnt + CW'(1);
      if (cnt_step == TERM) begin
        deb_hit = 1'b1;
      end else begin
        cnt_next = cnt_step;
      end
    end
  end

  // Register decode: write strobes and the zero-extended read value.
  always_comb begin
    led_wr  = 1'b0;
    stat_rd = 1'b0;
    rd_val  = '0;
    if (bus_req && bus_we) begin
      led_wr = (bus_addr == LED_ADDR);
    end else if (bus_req) begin
      if (bus_addr == LED_ADDR) begin
        rd_val[3:0] = LEDs;
      end else if (bus_addr == SW_ADDR) begin
        rd_val[3:0] = stable;
      end else if (bus_addr == STAT_ADDR) begin
        rd_val[0] = changed;
        stat_rd   = 1'b1;
      end
    end
  end

  // Switch synchronizer, debounce counter and change flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      changed <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      cnt   <= cnt_next;
      if (deb_hit) begin
        stable <= sync1;
      end
      // A fresh debounce event wins over a clearing status read.
      if (deb_hit) begin
        changed <= 1'b1;
      end else if (stat_rd) begin
        changed <= 1'b0;
      end
    end
  end

  // Bus acknowledge, read data and LED register.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      LEDs      <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rd_val;
      if (led_wr) begin
        LEDs <= bus_wdata[3:0];
      end
    end
  end

endmodule

// File: tb/tb_scic_io_port.sv
// tb/tb_scic_io_port.sv - self-checking bench for scic_io_port
module tb_scic_io_port;

  logic        clock;
  logic        reset;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic [3:0]  switches;
  logic [3:0]  LEDs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        exp_ack;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs[10];

  scic_io_port #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (16),
    .LED_ADDR       (8'hF0),
    .SW_ADDR        (8'hF1),
    .STAT_ADDR      (8'hF2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .switches (switches),
    .LEDs     (LEDs)
  );

  // 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic req, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata);
    bus_req   = req;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    tick();
    bus_req = 1'b0;
    bus_we  = 1'b0;
  endtask

  // Read a register and check that it acks with the given data.
  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [15:0] exp);
    bus_op(1'b1, 1'b0, addr, 16'h0);
    chk({name, "_ack"}, 32'(bus_ack), 32'd1);
    chk({name, "_rd"}, 32'(bus_rdata), 32'(exp));
  endtask

  initial begin
    // write F0, read F0, writes to F1/F3, back-to-back mix, idle gap
    vecs[0] = '{1, 1, 8'hF0, 16'hABC5, 1, 0, 16'h0000, 4'h5};
    vecs[1] = '{1, 0, 8'hF0, 16'h0000, 1, 1, 16'h0005, 4'h5};
    vecs[2] = '{1, 1, 8'hF1, 16'hFFFF, 1, 0, 16'h0000, 4'h5};
    vecs[3] = '{1, 1, 8'hF3, 16'h000E, 1, 0, 16'h0000, 4'h5};
    vecs[4] = '{1, 0, 8'hF3, 16'h0000, 1, 1, 16'h0000, 4'h5};
    vecs[5] = '{0, 0, 8'hF0, 16'h0000, 0, 1, 16'h0000, 4'h5};
    vecs[6] = '{1, 1, 8'hF0, 16'h123A, 1, 0, 16'h0000, 4'hA};
    vecs[7] = '{1, 0, 8'hF0, 16'h0000, 1, 1, 16'h000A, 4'hA};
    vecs[8] = '{1, 0, 8'hF1, 16'h0000, 1, 1, 16'h0000, 4'hA};
    vecs[9] = '{1, 0, 8'hF2, 16'h0000, 1, 1, 16'h0000, 4'hA};

    // 1: reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_req   = 1'($urandom);
      bus_we    = 1'($urandom);
      bus_addr  = 8'hF0 + 8'($urandom_range(0, 3));
      bus_wdata = 16'($urandom);
      switches  = 4'($urandom);
      tick();
      chk("rst_leds", 32'(LEDs), 32'd0);
      chk("rst_ack", 32'(bus_ack), 32'd0);
      chk("rst_rdata", 32'(bus_rdata), 32'd0);
    end
    reset    = 1'b0;
    switches = 4'h0;
    bus_req  = 1'b0;
    bus_we   = 1'b0;
    rd_chk("rst_sw", 8'hF1, 16'h0000);

    // 2: table of bus vectors, one per cycle
    for (int i = 0; i < 10; i++) begin
      bus_req   = vecs[i].req;
      bus_we    = vecs[i].we;
      bus_addr  = vecs[i].addr;
      bus_wdata = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(bus_ack), 32'(vecs[i].exp_ack));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(bus_rdata), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_leds", i), 32'(LEDs), 32'(vecs[i].exp_leds));
    end
    bus_req = 1'b0;
    tick();
    chk("idle_ack", 32'(bus_ack), 32'd0);
    chk("idle_rdata", 32'(bus_rdata), 32'd0);

    // 3: debounce accept; first read shares the sync1 capture edge
    switches = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      rd_chk($sformatf("deb_sw%0d", i), 8'hF1, (i == 5) ? 16'h000A : 16'h0000);
    end
    rd_chk("deb_stat1", 8'hF2, 16'h0001);
    rd_chk("deb_stat2", 8'hF2, 16'h0000);

    // 4: glitch reject from a clean state, then a long pulse
    reset = 1'b1;
    switches = 4'h0;
    tick();
    reset = 1'b0;
    chk("rst2_leds", 32'(LEDs), 32'd0);
    switches = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    switches = 4'b0000;
    for (int i = 0; i < 8; i++) tick();
    rd_chk("glitch_sw", 8'hF1, 16'h0000);
    rd_chk("glitch_stat", 8'hF2, 16'h0000);
    switches = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    rd_chk("pulse_sw", 8'hF1, 16'h0001);
    rd_chk("pulse_stat", 8'hF2, 16'h0001);

    // 5: STAT read on the same edge stable updates
    switches = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    rd_chk("coll_stat1", 8'hF2, 16'h0000);
    rd_chk("coll_stat2", 8'hF2, 16'h0001);
    rd_chk("coll_sw", 8'hF1, 16'h0000);

    // 6: reset two cycles into a count, on a request edge
    switches = 4'b1111;
    tick();
    tick();
    reset     = 1'b1;
    bus_req   = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = 8'hF1;
    tick();
    chk("mid_rst_ack", 32'(bus_ack), 32'd0);
    chk("mid_rst_rdata", 32'(bus_rdata), 32'd0);
    reset   = 1'b0;
    bus_req = 1'b0;
    tick();
    chk("post_rst_ack", 32'(bus_ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd_chk($sformatf("restart_sw%0d", i), 8'hF1, (i == 4) ? 16'h000F : 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
